// File: rtl/lm07_pkg.sv
// Shared constants, types and helpers for the LM07 temperature display.
package lm07_pkg;

  // Counter widths
  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;

  // uio bit positions
  localparam int unsigned UIO_CS       = 0;
  localparam int unsigned UIO_SCK      = 1;
  localparam int unsigned UIO_DISP_LSB = 2;
  localparam int unsigned UIO_SIO      = 5;

  // Direction mask: CS, SCK and the three digit enables are outputs
  localparam logic [7:0] UIO_OE_MASK = 8'b0001_1111;

  // Segment patterns {g,f,e,d,c,b,a} for digits 0..9
  localparam logic [6:0] SEG_CODES [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Digit code that decodes to all segments off
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } spi_state_e;

  // Exact 9-bit binary to 3-digit BCD {hund,tens,ones} by shift-and-add-3
  function automatic logic [11:0] bin_to_bcd(input logic [8:0] bin);
    logic [20:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 9; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (sh[9 + 4*d +: 4] >= 4'd5) begin
          sh[9 + 4*d +: 4] = sh[9 + 4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[20:9];
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Decimal digit to seven-segment pattern; codes above 9 blank the display.
module bcd_to_7seg
  import lm07_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  // Table lookup with blanking for non-decimal codes
  always_comb begin
    seg_c = 7'h00;
    case (digit)
      4'd0: seg_c = SEG_CODES[0];
      4'd1: seg_c = SEG_CODES[1];
      4'd2: seg_c = SEG_CODES[2];
      4'd3: seg_c = SEG_CODES[3];
      4'd4: seg_c = SEG_CODES[4];
      4'd5: seg_c = SEG_CODES[5];
      4'd6: seg_c = SEG_CODES[6];
      4'd7: seg_c = SEG_CODES[7];
      4'd8: seg_c = SEG_CODES[8];
      4'd9: seg_c = SEG_CODES[9];
      default: seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/tt_um_silicon_tinytapeout_lm07.sv
// Polls an LM07/LM70 SPI sensor, converts to decimal C or F and drives a 7-seg display.
module tt_um_silicon_tinytapeout_lm07
  import lm07_pkg::*;
#(
  parameter int unsigned SCK_HALF  = 2,
  parameter int unsigned POLL_WAIT = 64,
  parameter int unsigned SCAN_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       temp_q, temp_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic [2:0]       scan_q, scan_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;

  logic             sio;
  logic [7:0]       c_val;
  logic [11:0]      f_mul;
  logic [11:0]      f_div;
  logic [8:0]       f_val;
  logic [8:0]       v_val;
  logic [11:0]      bcd;
  logic [3:0]       hund, tens, ones;
  logic [3:0]       digit_sel;
  logic             dp;
  logic [2:0]       disp;
  logic [6:0]       seg_c;
  logic             unused_ok;

  assign sio       = uio_in[UIO_SIO];
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in[7:6], uio_in[4:0]};

  // State and data registers; reset aborts any frame with CS high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      temp_q     <= '0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      scan_q     <= 3'b001;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      temp_q     <= temp_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      scan_q     <= scan_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  // SPI master: wait with CS high, clock in 8 bits MSB-first, latch the byte
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    temp_d  = temp_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    case (state_q)
      ST_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (cnt_q == CNT_W'(POLL_WAIT)) begin
          cnt_d   = '0;
          cs_d    = 1'b0;
          bit_d   = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q == CNT_W'(SCK_HALF - 1)) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], sio};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (cnt_q == CNT_W'(SCK_HALF - 1)) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q == BIT_W'(7)) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        cs_d    = 1'b1;
        temp_d  = shift_q;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Digit scanner for the external multiplexed display
  always_comb begin
    scan_d     = scan_q;
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_d     = {scan_q[1:0], scan_q[2]};
    end
  end

  // Temperature conversion: 2 C per LSB, negatives clamp to 0, optional F
  always_comb begin
    c_val = temp_q[7] ? 8'd0 : {temp_q[6:0], 1'b0};
    f_mul = 12'(c_val) * 12'd9;
    f_div = f_mul / 12'd5;
    f_val = 9'(f_div) + 9'd32;
    v_val = ui_in[2] ? f_val : 9'(c_val);
    bcd   = bin_to_bcd(v_val);
    hund  = bcd[11:8];
    tens  = bcd[7:4];
    ones  = bcd[3:0];
  end

  // Digit selection: fixed onboard digit or scanned external digits
  always_comb begin
    digit_sel = tens;
    dp        = 1'b0;
    disp      = 3'b000;
    if (!ui_in[0]) begin
      digit_sel = ui_in[1] ? ones : tens;
      dp        = (hund != 4'd0);
    end else begin
      disp = scan_q;
      case (scan_q)
        3'b001:  digit_sel = ones;
        3'b010:  digit_sel = tens;
        3'b100:  digit_sel = (hund == 4'd0) ? DIGIT_BLANK : hund;
        default: digit_sel = DIGIT_BLANK;
      endcase
    end
  end

  bcd_to_7seg u_seg (
    .digit (digit_sel),
    .seg_c (seg_c)
  );

  // Pin mapping
  always_comb begin
    uo_out                       = {dp, seg_c};
    uio_out                      = 8'h00;
    uio_out[UIO_CS]              = cs_q;
    uio_out[UIO_SCK]             = sck_q;
    uio_out[UIO_DISP_LSB +: 3]   = disp;
    uio_oe                       = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_tt_um_silicon_tinytapeout_lm07.sv
// Scoreboard bench for the LM07 display: sensor model, frame checker, display monitor.
module tb_tt_um_silicon_tinytapeout_lm07;

  localparam int unsigned POLL_WAIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;

  tt_um_silicon_tinytapeout_lm07 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Sensor model: word reloads on any CS edge, shifts on falling edge of (~CS & SCK)
  logic [15:0] sensor_word = 16'h311F;
  logic [15:0] sens_sh = 16'h0000;
  logic        cs, sck, sck_gate;
  logic        cs_last = 1'b1;
  logic        gate_last = 1'b0;

  assign cs       = uio_out[0];
  assign sck      = uio_out[1];
  assign sck_gate = ~cs & sck;
  assign uio_in   = {2'b00, sens_sh[15], 5'b00000};

  always @(cs or sck_gate) begin
    if (cs !== cs_last) begin
      sens_sh = sensor_word;
    end else if (gate_last && !sck_gate) begin
      sens_sh = {sens_sh[14:0], 1'b0};
    end
    cs_last   = cs;
    gate_last = sck_gate;
  end

  // Scoreboard of expected display states
  typedef struct {
    string      tag;
    logic [7:0] uo;
    logic [2:0] disp;
    bit         chk_cs;
  } exp_t;

  exp_t sb[$];
  int   mon_wait = 0;

  // Monitor: pops an entry once the DUT enables the expected digit, then compares
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (uio_out[4:2] == sb[0].disp) begin
        checks++;
        if (uo_out !== sb[0].uo) begin
          failures++;
          $display("FAIL %s: uo_out got %02h want %02h", sb[0].tag, uo_out, sb[0].uo);
        end
        if (sb[0].chk_cs) begin
          checks++;
          if (cs !== 1'b1) begin
            failures++;
            $display("FAIL %s_cs: cs got %b want 1", sb[0].tag, cs);
          end
        end
        void'(sb.pop_front());
        mon_wait = 0;
      end else begin
        mon_wait++;
        if (mon_wait > 100) begin
          checks++;
          failures++;
          $display("FAIL %s: disp got %b want %b (timeout)", sb[0].tag, uio_out[4:2], sb[0].disp);
          void'(sb.pop_front());
          mon_wait = 0;
        end
      end
    end
  end

  // Frame checker: 8 SCK rises per CS-low window, CS high long enough
  int  fr_edges = 0;
  int  fr_hi = 0;
  bit  fr_skip = 1'b1;
  logic fr_cs_p = 1'b1;
  logic fr_sck_p = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      fr_edges = 0;
      fr_skip  = 1'b1;
    end else begin
      if (!cs && sck && !fr_sck_p) fr_edges++;
      if (cs && !fr_cs_p) begin
        if (!fr_skip) begin
          checks++;
          if (fr_edges != 8) begin
            failures++;
            $display("FAIL frame_sck_edges: got %0d want 8", fr_edges);
          end
        end
        fr_skip  = 1'b0;
        fr_edges = 0;
      end
      if (!cs && fr_cs_p) begin
        checks++;
        if (fr_hi < POLL_WAIT) begin
          failures++;
          $display("FAIL frame_cs_high: got %0d cycles want >= %0d", fr_hi, POLL_WAIT);
        end
      end
    end
    fr_hi    = cs ? fr_hi + 1 : 0;
    fr_cs_p  = cs;
    fr_sck_p = sck;
  end

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
    end
    checks++;
    failures++;
    $display("FAIL drain: %0d entries left want 0", sb.size());
    sb.delete();
  endtask

  task automatic expect_out(input string tag, input logic [2:0] ui, input logic [7:0] uo,
                            input logic [2:0] disp);
    exp_t e;
    @(posedge clk);
    #1;
    ui_in = {5'b00000, ui};
    e.tag = tag; e.uo = uo; e.disp = disp; e.chk_cs = 1'b0;
    sb.push_back(e);
    drain();
  endtask

  task automatic wait_frames(input int n);
    int   got;
    logic last;
    got  = 0;
    last = cs;
    for (int i = 0; i < 250 * n && got < n; i++) begin
      @(posedge clk);
      #1;
      if (cs && !last) got++;
      last = cs;
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL wait_frames: got %0d frames want %0d", got, n);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    // Reset state: CS high, display shows 0
    sensor_word = 16'h311F;
    repeat (3) @(posedge clk);
    #1;
    e.tag = "reset_hold"; e.uo = 8'h3F; e.disp = 3'b000; e.chk_cs = 1'b1;
    sb.push_back(e);
    drain();
    checks++;
    if (uio_oe !== 8'h1F) begin
      failures++;
      $display("FAIL uio_oe: got %02h want 1f", uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("post_reset_zero", 3'b000, 8'h3F, 3'b000);

    // 0x311F -> 98 C / 208 F
    wait_frames(1);
    expect_out("c98_tens",  3'b000, 8'h6F, 3'b000);
    expect_out("c98_ones",  3'b010, 8'h7F, 3'b000);
    expect_out("f208_tens_dp", 3'b100, 8'hBF, 3'b000);
    expect_out("f208_ext_ones", 3'b101, 8'h7F, 3'b001);
    expect_out("f208_ext_tens", 3'b101, 8'h3F, 3'b010);
    expect_out("f208_ext_hund", 3'b101, 8'h5B, 3'b100);

    // 0x251F -> 74 C
    sensor_word = 16'h251F;
    wait_frames(2);
    expect_out("c74_tens", 3'b000, 8'h07, 3'b000);
    expect_out("c74_ones", 3'b010, 8'h66, 3'b000);

    // 0x019F -> 2 C, hundreds blanked externally
    sensor_word = 16'h019F;
    wait_frames(2);
    expect_out("c2_tens", 3'b000, 8'h3F, 3'b000);
    expect_out("c2_ones", 3'b010, 8'h5B, 3'b000);
    expect_out("c2_ext_hund_blank", 3'b001, 8'h00, 3'b100);
    expect_out("c2_ext_ones", 3'b001, 8'h5B, 3'b001);
    expect_out("c2_ext_tens", 3'b001, 8'h3F, 3'b010);

    // 0xF000 negative -> 0 C / 32 F
    sensor_word = 16'hF000;
    wait_frames(2);
    expect_out("neg_c_tens", 3'b000, 8'h3F, 3'b000);
    expect_out("neg_c_ones", 3'b010, 8'h3F, 3'b000);
    expect_out("neg_f_tens", 3'b100, 8'h4F, 3'b000);
    expect_out("neg_f_ones", 3'b110, 8'h5B, 3'b000);

    // 0x7F00 max -> 254 C / 489 F
    sensor_word = 16'h7F00;
    wait_frames(2);
    expect_out("c254_tens_dp", 3'b000, 8'hED, 3'b000);
    expect_out("c254_ext_hund", 3'b001, 8'h5B, 3'b100);
    expect_out("c254_ext_ones", 3'b001, 8'h66, 3'b001);
    expect_out("f489_tens_dp", 3'b100, 8'hFF, 3'b000);
    expect_out("f489_ones_dp", 3'b110, 8'hEF, 3'b000);

    // Mid-frame reset: CS rises at once, temperature cleared
    ui_in = 8'h00;
    for (int i = 0; i < 200 && cs; i++) @(posedge clk);
    repeat (7) @(posedge clk);
    #2;
    checks++;
    if (cs !== 1'b0) begin
      failures++;
      $display("FAIL midframe_setup: cs got %b want 0", cs);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b1) begin
      failures++;
      $display("FAIL midframe_cs_immediate: cs got %b want 1", cs);
    end
    e.tag = "midframe_reset_zero"; e.uo = 8'h3F; e.disp = 3'b000; e.chk_cs = 1'b1;
    sb.push_back(e);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_out("after_abort_zero", 3'b000, 8'h3F, 3'b000);
    wait_frames(1);
    expect_out("after_abort_c254", 3'b000, 8'hED, 3'b000);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
